stack_controller: RTL and testbench
===================================

Name: stack_controller

Overview:
- Sequences the calculator's stack: shares the stack pointer and stack RAM between two requesters, Call unit (port 0) and ALU/PUSH-POP unit (port 1).
- Pulses the stack pointer's INC/DEC strobes, drives the stack RAM, checks overflow/underflow and returns popped data.
- Sits between the control unit and the stack pointer + data memory.

Parameters:
- STACK_TOP, 16'h01FF, empty-stack SP value (stack pointer reset value)
- STACK_BOTTOM, 16'h0100, lowest writable stack address

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset, synchronous, active-low
- REQ0  in  1  port-0 request; held until DONE0
- OP0  in  1  port-0 operation: 1=push, 0=pop
- WDATA0  in  16  port-0 push data
- REQ1  in  1  port-1 request; held until DONE1
- OP1  in  1  port-1 operation: 1=push, 0=pop
- WDATA1  in  16  port-1 push data
- GNT0, GNT1  out  1 each  grant; high for the whole transaction
- DONE0, DONE1  out  1 each  one-cycle completion pulse
- RDATA  out  16  popped data; valid from DONE, held until next pop completes
- ERR  out  1  one-cycle pulse with DONE on rejected push (full) or pop (empty)
- SP_VAL  in  16  current stack pointer value
- SP_INC, SP_DEC  out  1 each  one-cycle strobes to the stack pointer
- MEM_ADDR  out  16  stack RAM address
- MEM_WDATA  out  16  stack RAM write data
- MEM_WE  out  1  RAM write enable
- MEM_RE  out  1  RAM read enable; MEM_RDATA valid the following cycle
- MEM_RDATA  in  16  RAM read data

Behaviour:
- Moore FSM. Outputs decode from registered state plus latched port id, op and data.
- States: IDLE, PUSH_WR, PUSH_SETTLE, POP_INC, POP_SETTLE, POP_RD, POP_CAP, FAIL, DONE.
- Reset (RST=0 at posedge), including mid-transaction:
  - state=IDLE; RDATA=0; last_served=1.
  - All strobes, grants, DONE and ERR = 0; MEM_ADDR and MEM_WDATA = 0.
  - An in-flight transaction is abandoned with no DONE.
- Arbitration (IDLE only, round-robin):
  - One request pending: grant it.
  - Both pending: grant the port not equal to last_served. First tie after reset goes to port 0.
  - last_served updates on entry to DONE or FAIL.
- Full/empty checks use SP_VAL sampled in IDLE:
  - push with SP_VAL >= STACK_BOTTOM -> PUSH_WR; otherwise -> FAIL
  - pop with SP_VAL < STACK_TOP -> POP_INC; otherwise -> FAIL
- PUSH_WR: MEM_ADDR=SP_VAL, MEM_WDATA=latched data, MEM_WE=1, SP_DEC=1 -> PUSH_SETTLE -> DONE.
- POP_INC: SP_INC=1 -> POP_SETTLE -> POP_RD.
- POP_RD: MEM_ADDR=SP_VAL, MEM_RE=1 -> POP_CAP.
- POP_CAP: RDATA <= MEM_RDATA -> DONE.
- SETTLE states wait one cycle for SP_VAL to reflect the strobe. SP_VAL is never sampled in the strobe cycle.
- DONE: DONEx=1 for the granted port -> IDLE.
- FAIL: DONEx=1, ERR=1. No RAM or SP activity; SP and RDATA unchanged -> IDLE.
- GNTx is high in every non-IDLE state of its transaction. GNT0 and GNT1 are never high together.
- Latency counts from the IDLE sampling edge to the DONE cycle, inclusive of DONE:
  - push: 3 cycles (PUSH_WR, PUSH_SETTLE, DONE)
  - pop: 5 cycles (POP_INC, POP_SETTLE, POP_RD, POP_CAP, DONE)
  - FAIL: 1 cycle
- After DONE the FSM spends at least one cycle in IDLE. A REQ still high in IDLE is a new request.
- REQ, OP and WDATA changes during a transaction are ignored; all are latched in IDLE.
- Stack discipline: SP points to the next free slot. Push writes then decrements; pop increments then reads. Capacity is STACK_TOP-STACK_BOTTOM+1 = 256 words.
- No wrap-around: the controller never drives SP below STACK_BOTTOM-1 or above STACK_TOP.

Test Plan:
- Push then pop: reset; port1 push 16'hBEEF -> write at 0x01FF, SP_DEC once, DONE1 at 3rd cycle; then port1 pop -> SP_INC, read 0x01FF, RDATA=16'hBEEF, DONE1 at 5th cycle, ERR=0.
- Underflow: pop on empty stack (SP_VAL=0x01FF) -> FAIL: DONE+ERR in the cycle after grant, no SP_INC/MEM_RE, RDATA unchanged.
- Overflow: 256 pushes succeed, SP_VAL ends at 0x00FF; 257th push -> ERR=1, MEM_WE never asserted.
- Round-robin: REQ0 and REQ1 held high together with pushes 16'h0001/16'h0002 -> grants alternate 0,1,0,1; GNT0 and GNT1 never overlap.
- Reset mid-pop: RST=0 during POP_RD -> next cycle IDLE, all outputs 0, no DONE; new request after RST=1 served normally.
- Request change mid-transaction: WDATA0 changed after grant -> RAM receives the originally latched value.

Source files
------------

// File: rtl/stack_controller.sv
// stack_controller: arbitrates two push/pop requesters onto one stack pointer
// and one stack RAM. Push writes at SP and then decrements SP. Pop increments
// SP and then reads at the new SP. Requests that would overflow or underflow
// the stack are rejected with ERR.
//
// Handshake: a requester holds REQx (with OPx/WDATAx) until it sees DONEx.
// GNTx is high for the whole transaction. DONEx is a one-cycle pulse.
// REQ, OP and WDATA are sampled only in IDLE, so changes during a transaction
// have no effect. The FSM always spends at least one cycle in IDLE between
// transactions.
module stack_controller #(
    parameter logic [15:0] STACK_TOP    = 16'h01FF,
    parameter logic [15:0] STACK_BOTTOM = 16'h0100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic        OP0,
    input  logic [15:0] WDATA0,
    input  logic        REQ1,
    input  logic        OP1,
    input  logic [15:0] WDATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [15:0] RDATA,
    output logic        ERR,
    input  logic [15:0] SP_VAL,
    output logic        SP_INC,
    output logic        SP_DEC,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        MEM_WE,
    output logic        MEM_RE,
    input  logic [15:0] MEM_RDATA,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_PUSH_WR     = 4'd1,
        S_PUSH_SETTLE = 4'd2,
        S_POP_INC     = 4'd3,
        S_POP_SETTLE  = 4'd4,
        S_POP_RD      = 4'd5,
        S_POP_CAP     = 4'd6,
        S_FAIL        = 4'd7,
        S_DONE        = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_port;        // port owning the current transaction
    logic [15:0] r_data;        // push data latched in IDLE
    logic [15:0] r_rdata;
    logic        r_last_served;

    logic        w_req_any;
    logic        w_pick;
    logic        w_op;
    logic [15:0] w_wdata;

    // Round-robin pick: on a tie, serve the port not served last.
    always_comb begin
        w_req_any = REQ0 | REQ1;
        w_pick    = (REQ0 && REQ1) ? ~r_last_served : REQ1;
        w_op      = w_pick ? OP1 : OP0;
        w_wdata   = w_pick ? WDATA1 : WDATA0;
    end

    // State register plus the latched transaction context and pop result.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= S_IDLE;
            r_port        <= 1'b0;
            r_data        <= 16'h0000;
            r_rdata       <= 16'h0000;
            r_last_served <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req_any) begin
                r_port <= w_pick;
                r_data <= w_wdata;
            end
            if (r_state == S_POP_CAP) begin
                r_rdata <= MEM_RDATA;
            end
            // A rejection goes straight from IDLE to FAIL, so r_port is not latched yet.
            if (w_next == S_FAIL) begin
                r_last_served <= w_pick;
            end else if (w_next == S_DONE && r_state != S_DONE) begin
                r_last_served <= r_port;
            end
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        w_next    = r_state;
        GNT0      = 1'b0;
        GNT1      = 1'b0;
        DONE0     = 1'b0;
        DONE1     = 1'b0;
        ERR       = 1'b0;
        SP_INC    = 1'b0;
        SP_DEC    = 1'b0;
        MEM_ADDR  = 16'h0000;
        MEM_WDATA = 16'h0000;
        MEM_WE    = 1'b0;
        MEM_RE    = 1'b0;

        if (r_state != S_IDLE) begin
            GNT0 = ~r_port;
            GNT1 = r_port;
        end

        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    if (w_op) begin
                        w_next = (SP_VAL >= STACK_BOTTOM) ? S_PUSH_WR : S_FAIL;
                    end else begin
                        w_next = (SP_VAL < STACK_TOP) ? S_POP_INC : S_FAIL;
                    end
                end
            end
            S_PUSH_WR: begin
                MEM_ADDR  = SP_VAL;
                MEM_WDATA = r_data;
                MEM_WE    = 1'b1;
                SP_DEC    = 1'b1;
                w_next    = S_PUSH_SETTLE;
            end
            S_PUSH_SETTLE: w_next = S_DONE;
            S_POP_INC: begin
                SP_INC = 1'b1;
                w_next = S_POP_SETTLE;
            end
            S_POP_SETTLE: w_next = S_POP_RD;
            S_POP_RD: begin
                MEM_ADDR = SP_VAL;
                MEM_RE   = 1'b1;
                w_next   = S_POP_CAP;
            end
            S_POP_CAP: w_next = S_DONE;
            S_FAIL: begin
                DONE0  = ~r_port_or_pick_unused();
                DONE1  = r_port;
                ERR    = 1'b1;
                w_next = S_IDLE;
            end
            S_DONE: begin
                DONE0  = ~r_port;
                DONE1  = r_port;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Keeps the FAIL decode identical in form to DONE.
    function automatic logic r_port_or_pick_unused();
        return r_port;
    endfunction

    assign RDATA       = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: drives stack_controller with directed and random
// push/pop transactions against an external stack pointer and RAM. It checks
// the results against a queue-based model of a 256-word stack.
module tb_stack_controller;

    localparam logic [15:0] TOP = 16'h01FF;
    localparam int          CAP = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ0 = 1'b0, OP0 = 1'b0, REQ1 = 1'b0, OP1 = 1'b0;
    logic [15:0] WDATA0 = 16'h0, WDATA1 = 16'h0;
    logic        GNT0, GNT1, DONE0, DONE1, ERR;
    logic [15:0] RDATA;
    logic [15:0] SP_VAL;
    logic        SP_INC, SP_DEC;
    logic [15:0] MEM_ADDR, MEM_WDATA;
    logic        MEM_WE, MEM_RE;
    logic [15:0] MEM_RDATA;
    logic [3:0]  dbg_state;

    stack_controller dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OP0(OP0), .WDATA0(WDATA0),
        .REQ1(REQ1), .OP1(OP1), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RDATA(RDATA), .ERR(ERR),
        .SP_VAL(SP_VAL), .SP_INC(SP_INC), .SP_DEC(SP_DEC),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / environment ----------------
    always #5 CLK = ~CLK;

    // Stack pointer and RAM that the controller drives
    logic [15:0] sp;
    logic [15:0] mem [0:65535];
    logic [15:0] mem_rd;
    assign SP_VAL    = sp;
    assign MEM_RDATA = mem_rd;

    always @(posedge CLK) begin
        if (!RST) sp <= TOP;
        else if (SP_INC) sp <= sp + 16'd1;
        else if (SP_DEC) sp <= sp - 16'd1;
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        if (MEM_RE) mem_rd <= mem[MEM_ADDR];
    end

    // Free-running event counters (transactions take deltas)
    int n_inc = 0, n_dec = 0, n_we = 0, n_re = 0, n_done = 0;
    int n_overlap = 0, n_range = 0;
    always @(posedge CLK) begin
        if (SP_INC) n_inc++;
        if (SP_DEC) n_dec++;
        if (MEM_WE) n_we++;
        if (MEM_RE) n_re++;
        if (DONE0 || DONE1) n_done++;
        if (GNT0 && GNT1) n_overlap++;
        if (RST && (sp > TOP || sp < 16'h00FF)) n_range++;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];      // model stack, back = top of stack
    logic [15:0] exp_rdata = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
        exp_rdata = 16'h0;
    endtask

    // Drive one transaction on a port. Returns latency (cycles to DONE
    // inclusive), ERR and RDATA at DONE. With tamper set, WDATA is changed
    // after the grant.
    task automatic drive_txn(input bit port, input bit op, input logic [15:0] data,
                             input bit tamper, output int lat, output bit err,
                             output logic [15:0] rd, output int gnt_bad);
        bit got;
        @(negedge CLK);
        if (port) begin REQ1 = 1'b1; OP1 = op; WDATA1 = data; end
        else      begin REQ0 = 1'b1; OP0 = op; WDATA0 = data; end
        lat = 0; got = 0; gnt_bad = 0; err = 0; rd = 16'h0;
        while (!got && lat < 20) begin
            @(negedge CLK);
            lat++;
            if (tamper && lat == 1) begin
                if (port) WDATA1 = ~data; else WDATA0 = ~data;
            end
            if ((port ? GNT1 : GNT0) !== 1'b1 || (port ? GNT0 : GNT1) !== 1'b0) gnt_bad++;
            if ((port ? DONE0 : DONE1) !== 1'b0) gnt_bad++;
            if ((port ? DONE1 : DONE0) === 1'b1) begin
                got = 1; err = ERR; rd = RDATA;
                if (port) REQ1 = 1'b0; else REQ0 = 1'b0;
            end
        end
        if (!got) begin
            if (port) REQ1 = 1'b0; else REQ0 = 1'b0;
            check("txn_timeout", 32'(lat), 32'(0));
        end
    endtask

    // Run a transaction and compare every visible effect with the stack model
    task automatic model_txn(input bit port, input bit op, input logic [15:0] data, input bit tamper);
        int lat, gb, i0, d0, w0, r0, depth;
        bit err;
        logic [15:0] rd, addr;
        int exp_lat, exp_inc, exp_dec, exp_we, exp_re;
        bit exp_err;
        depth = exp_q.size();
        addr = TOP - 16'(depth);
        i0 = n_inc; d0 = n_dec; w0 = n_we; r0 = n_re;
        exp_inc = 0; exp_dec = 0; exp_we = 0; exp_re = 0;
        if (op) begin
            if (depth < CAP) begin
                exp_lat = 3; exp_err = 0; exp_dec = 1; exp_we = 1;
                exp_q.push_back(data);
            end else begin
                exp_lat = 1; exp_err = 1;
            end
        end else begin
            if (depth > 0) begin
                exp_lat = 5; exp_err = 0; exp_inc = 1; exp_re = 1;
                exp_rdata = exp_q.pop_back();
            end else begin
                exp_lat = 1; exp_err = 1;
            end
        end
        drive_txn(port, op, data, tamper, lat, err, rd, gb);
        check(op ? "push_latency" : "pop_latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(err), 32'(exp_err));
        check("rdata", 32'(rd), 32'(exp_rdata));
        check("grant_done_port", 32'(gb), 32'(0));
        check("sp_after", 32'(sp), 32'(TOP - 16'(exp_q.size())));
        check("sp_inc_count", 32'(n_inc - i0), 32'(exp_inc));
        check("sp_dec_count", 32'(n_dec - d0), 32'(exp_dec));
        check("mem_we_count", 32'(n_we - w0), 32'(exp_we));
        check("mem_re_count", 32'(n_re - r0), 32'(exp_re));
        if (op && !exp_err) check("mem_written", 32'(mem[addr]), 32'(data));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, gb, done0;
        bit err, port_seen, timed_out;
        logic [15:0] rd;

        for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
        mem_rd = 16'h0;

        // Reset state
        do_reset();
        @(negedge CLK);
        check("reset_state", 32'(dbg_state), 32'(0));
        check("reset_outputs", {16'h0, 5'h0, GNT0, GNT1, DONE0, DONE1, ERR, SP_INC, SP_DEC, MEM_WE, MEM_RE, 2'h0},
              32'(0));
        check("reset_rdata", 32'(RDATA), 32'(0));
        check("reset_mem_bus", {MEM_ADDR, MEM_WDATA}, 32'(0));

        // Push then pop on port 1
        model_txn(1'b1, 1'b1, 16'hBEEF, 1'b0);
        check("beef_at_top", 32'(mem[16'h01FF]), 32'h0000BEEF);
        model_txn(1'b1, 1'b0, 16'h0000, 1'b0);
        check("beef_popped", 32'(RDATA), 32'h0000BEEF);

        // Underflow on port 0: rejected, RDATA unchanged
        model_txn(1'b0, 1'b0, 16'h0000, 1'b0);

        // Round robin: both held high from a fresh reset
        do_reset();
        @(negedge CLK);
        OP0 = 1'b1; WDATA0 = 16'h0001; OP1 = 1'b1; WDATA1 = 16'h0002;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            timed_out = 1;
            for (int c = 0; c < 20; c++) begin
                @(negedge CLK);
                if (DONE0 || DONE1) begin timed_out = 0; break; end
            end
            port_seen = DONE1;
            check("rr_timeout", 32'(timed_out), 32'(0));
            check("rr_grant_order", 32'(port_seen), 32'(k % 2));
            exp_q.push_back((k % 2) ? 16'h0002 : 16'h0001);
            if (k == 3) begin REQ0 = 1'b0; REQ1 = 1'b0; end
        end
        check("rr_sp", 32'(sp), 32'(TOP - 16'd4));
        for (int k = 0; k < 4; k++) model_txn(1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0);

        // Request changed after grant: the latched value goes to RAM
        model_txn(1'b0, 1'b1, 16'h1234, 1'b1);
        model_txn(1'b0, 1'b0, 16'h0, 1'b0);
        check("tamper_pop", 32'(RDATA), 32'h00001234);

        // Overflow: fill the 256-word stack, then one more push
        do_reset();
        for (int k = 0; k < CAP; k++) model_txn(1'($urandom_range(0, 1)), 1'b1, 16'($urandom), 1'b0);
        check("full_sp", 32'(sp), 32'h000000FF);
        model_txn(1'b1, 1'b1, 16'hDEAD, 1'b0);
        check("full_sp_held", 32'(sp), 32'h000000FF);

        // Random mix against the model
        for (int k = 0; k < 80; k++)
            model_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);

        // Reset during POP_RD abandons the pop with no DONE
        model_txn(1'b1, 1'b1, 16'h5A5A, 1'b0);
        @(negedge CLK);
        REQ1 = 1'b1; OP1 = 1'b0;
        timed_out = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (MEM_RE) begin timed_out = 0; break; end
        end
        check("pop_rd_reached", 32'(timed_out), 32'(0));
        done0 = n_done;
        RST = 1'b0; REQ1 = 1'b0;
        @(negedge CLK);
        check("midreset_state", 32'(dbg_state), 32'(0));
        check("midreset_outputs", {16'h0, 5'h0, GNT0, GNT1, DONE0, DONE1, ERR, SP_INC, SP_DEC, MEM_WE, MEM_RE, 2'h0},
              32'(0));
        check("midreset_bus", {MEM_ADDR, MEM_WDATA}, 32'(0));
        check("midreset_rdata", 32'(RDATA), 32'(0));
        check("midreset_no_done", 32'(n_done - done0), 32'(0));
        RST = 1'b1;
        exp_q.delete();
        exp_rdata = 16'h0;
        model_txn(1'b0, 1'b1, 16'hC0DE, 1'b0);
        model_txn(1'b1, 1'b0, 16'h0, 1'b0);

        check("gnt_overlap", 32'(n_overlap), 32'(0));
        check("sp_range", 32'(n_range), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
